// File: rtl/depth_line_streamer_if.sv
// AXI4-Stream RGB pixel channel: 24-bit {R,G,B} beat with start-of-frame (tuser) and end-of-line (tlast) markers.
interface depth_line_streamer_if #(
  parameter int DATA_WIDTH = 24
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/depth_line_streamer.sv
// Ping-pong line buffer between the Mandelbrot engine and an AXI4-Stream RGB sink; first beat <=2 cycles after swap.
// Backpressure: a stalled beat holds in the output register, and the engine is never started more than one line ahead.
module depth_line_streamer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int MAX_ITER      = 200,
  parameter int DEPTH_WIDTH   = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  output logic                            start_out,
  input  logic                            module_done,
  input  logic [DEPTH_WIDTH-1:0]          depth_in,
  input  logic                            we_in,
  input  logic [$clog2(SCREEN_WIDTH)-1:0] addr_in,
  depth_line_streamer_if.master           m,
  output logic                            err
);

  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  localparam int CW = $clog2(SCREEN_WIDTH + 1);

  localparam logic [XW-1:0]          X_LAST  = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0]          Y_LAST  = YW'(SCREEN_HEIGHT - 1);
  localparam logic [CW-1:0]          C_FULL  = CW'(SCREEN_WIDTH);
  localparam logic [DEPTH_WIDTH-1:0] D_INSET = DEPTH_WIDTH'(MAX_ITER);

  localparam logic [1:0] F_IDLE  = 2'd0;
  localparam logic [1:0] F_START = 2'd1;
  localparam logic [1:0] F_FILL  = 2'd2;
  localparam logic [1:0] F_SWAP  = 2'd3;

  localparam logic S_IDLE   = 1'b0;
  localparam logic S_STREAM = 1'b1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t colour_map(input logic [DEPTH_WIDTH-1:0] d);
    rgb_t c;
    c = '0;
    if (d < D_INSET) begin
      c.r = d[7:0];
      c.g = {d[5:0], 2'b00};
      c.b = 8'hFF - d[7:0];
    end
    return c;
  endfunction

  // ---------------- fill side ----------------
  logic [1:0]    fstate;
  logic          sstate;
  logic          done_q;
  logic          fill_bank;
  logic [CW-1:0] wcount;
  logic [CW-1:0] wcount_nxt;
  logic          wr_oob;
  logic          wr_ok;
  logic          line_done;
  logic          handoff;

  assign wr_oob     = we_in && (addr_in > X_LAST);
  assign wr_ok      = we_in && !wr_oob && (fstate == F_FILL);
  assign wcount_nxt = wcount + CW'(wr_ok);
  // A write landing on the same cycle as the done edge still belongs to this line.
  assign line_done  = (fstate == F_FILL) && module_done && !done_q;
  assign handoff    = (fstate == F_SWAP) && (sstate == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fstate    <= F_IDLE;
      start_out <= 1'b0;
      done_q    <= 1'b0;
      fill_bank <= 1'b0;
      wcount    <= '0;
      err       <= 1'b0;
    end else begin
      done_q    <= module_done;
      start_out <= 1'b0;
      if (wr_ok) begin
        wcount <= wcount_nxt;
      end
      if ((we_in && (fstate != F_FILL)) || wr_oob || (line_done && (wcount_nxt != C_FULL))) begin
        err <= 1'b1;
      end
      case (fstate)
        F_IDLE: begin
          if (enable) begin
            fstate <= F_START;
          end
        end
        F_START: begin
          start_out <= 1'b1;
          fstate    <= F_FILL;
        end
        F_FILL: begin
          if (line_done) begin
            fstate <= F_SWAP;
          end
        end
        F_SWAP: begin
          if (handoff) begin
            fill_bank <= ~fill_bank;
            wcount    <= '0;
            fstate    <= enable ? F_START : F_IDLE;
          end
        end
        default: fstate <= F_IDLE;
      endcase
    end
  end

  // ---------------- line buffers ----------------
  logic [DEPTH_WIDTH-1:0] mem [2][SCREEN_WIDTH];
  logic [DEPTH_WIDTH-1:0] rd_dat;
  logic [CW-1:0]          rd_x;
  logic                   rd_en;

  // Stream side always owns the bank the fill side is not writing.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[fill_bank][addr_in] <= depth_in;
    end
    if (rd_en) begin
      rd_dat <= mem[~fill_bank][rd_x[XW-1:0]];
    end
  end

  // ---------------- stream side ----------------
  logic          rd_vld;
  logic [XW-1:0] rd_px;
  logic [YW-1:0] sy;
  logic          tvalid_q;
  rgb_t          tdata_q;
  logic          tlast_q;
  logic          tuser_q;
  logic          out_adv;
  logic          rd_adv;
  logic          beat_done;

  assign out_adv   = !tvalid_q || m.tready;
  assign rd_adv    = out_adv || !rd_vld;
  assign rd_en     = rd_adv && (sstate == S_STREAM) && (rd_x != C_FULL);
  assign beat_done = tvalid_q && m.tready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sstate   <= S_IDLE;
      rd_x     <= '0;
      rd_vld   <= 1'b0;
      rd_px    <= '0;
      sy       <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end else begin
      if (rd_adv) begin
        rd_vld <= rd_en;
        if (rd_en) begin
          rd_px <= rd_x[XW-1:0];
          rd_x  <= rd_x + 1'b1;
        end
      end
      if (out_adv) begin
        tvalid_q <= rd_vld;
        if (rd_vld) begin
          tdata_q <= colour_map(rd_dat);
          tlast_q <= (rd_px == X_LAST);
          tuser_q <= (rd_px == '0) && (sy == '0);
        end
      end
      case (sstate)
        S_IDLE: begin
          if (handoff) begin
            sstate <= S_STREAM;
            rd_x   <= '0;
          end
        end
        S_STREAM: begin
          if (beat_done && tlast_q) begin
            sstate <= S_IDLE;
            sy     <= (sy == Y_LAST) ? '0 : sy + 1'b1;
          end
        end
        default: sstate <= S_IDLE;
      endcase
    end
  end

  assign m.tvalid = tvalid_q;
  assign m.tdata  = tdata_q;
  assign m.tlast  = tlast_q;
  assign m.tuser  = tuser_q;

endmodule

// File: doc/depth_line_streamer.md
# depth_line_streamer

Consumer for the Mandelbrot line engine's pixel-write port. Captures per-pixel depth writes (`depth`/`we`/`addr`) into a ping-pong pair of line buffers and paces the engine with one-cycle `start_out` pulses. Streams each completed line as colour-mapped 24-bit RGB over an AXI4-Stream master with start-of-frame (`m_tuser`) and end-of-line (`m_tlast`) markers. Sits between the engine top and the video output or DMA path, so computation of line N+1 overlaps streaming of line N.

## Interface
- `SCREEN_WIDTH`, 640, pixels per line
- `SCREEN_HEIGHT`, 480, lines per frame
- `MAX_ITER`, 200, depth value meaning "inside set"
- `DEPTH_WIDTH`, 10, width of depth samples
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  level; allow new lines to be requested
- `start_out`  out  1  one-cycle pulse to engine `start`
- `module_done`  in  1  engine line-complete level
- `depth_in`  in  DEPTH_WIDTH  pixel depth
- `we_in`  in  1  depth write strobe
- `addr_in`  in  $clog2(SCREEN_WIDTH)  pixel x
- `m_tdata`  out  24  RGB {R,G,B}
- `m_tvalid`  out  1  stream valid
- `m_tready`  in  1  stream ready
- `m_tlast`  out  1  last pixel of line
- `m_tuser`  out  1  first pixel of frame
- `err`  out  1  sticky protocol error

## Operation
- Two banks, each SCREEN_WIDTH × DEPTH_WIDTH. Each bank has an owner: the fill side or the stream side.
- Fill FSM states:
  - F_IDLE: when `enable`=1 → F_START.
  - F_START: assert `start_out` for one cycle → F_FILL.
  - F_FILL: each `we_in`=1 writes `depth_in` to fill bank[`addr_in`] and increments `wcount`. A rising edge of `module_done` (registered previous value 0, current 1) is line complete → F_SWAP.
  - F_SWAP: wait until stream FSM is S_IDLE. Hand the fill bank to the stream side and swap banks. Clear `wcount`. Then → F_START if `enable`=1, else → F_IDLE.
- `module_done` high on entry to F_FILL without a preceding low cycle is not an edge; only 0→1 counts.
- Stream FSM states:
  - S_IDLE: on handoff → S_STREAM with `sx`=0.
  - S_STREAM: emit pixels `sx`=0..SCREEN_WIDTH-1. After the beat with `sx`=SCREEN_WIDTH-1 is accepted, increment `sy` (wrapping SCREEN_HEIGHT-1→0) → S_IDLE.
- Colour map:
  - depth ≥ MAX_ITER → 24'h000000.
  - Otherwise R = depth[7:0], G = {depth[5:0],2'b00}, B = 8'hFF − depth[7:0].
- Stream markers: `m_tlast` = (`sx`==SCREEN_WIDTH-1); `m_tuser` = (`sx`==0 && `sy`==0).
- Errors set `err` (sticky until reset); the offending write is dropped:
  - `we_in` with `addr_in` ≥ SCREEN_WIDTH.
  - `we_in` outside F_FILL.
  - Line complete with `wcount` ≠ SCREEN_WIDTH.
- Dropping `enable` mid-line: the current line completes and is streamed; no further `start_out` is issued.

## Timing
- Reset values: `start_out`=0, `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `m_tuser`=0, `err`=0. Both FSMs idle, `sy`=0, `wcount`=0. Bank contents are undefined.
- Reset asserted mid-operation: abort everything immediately; no partial line is emitted afterwards.
- `start_out` rises 2 cycles after `enable` is first sampled high in F_IDLE (F_IDLE→F_START, then the registered pulse).
- Buffer RAM is synchronous, read latency 1.
- First `m_tvalid` occurs ≤2 cycles after handoff.
- At most one bubble between beats when `m_tready`=1 continuously. Target is full throughput: one beat per cycle after the first.
- AXI rules:
  - While `m_tvalid`=1 and `m_tready`=0, `m_tdata`/`m_tlast`/`m_tuser` hold stable and `m_tvalid` stays high.
  - `m_tvalid` never depends combinationally on `m_tready`.
- Simultaneous line complete and stream busy: fill stays in F_SWAP, so no `start_out` is issued until the swap. The engine is therefore never more than one line ahead.
- Next-line `start_out` pulses 1 cycle after the swap.
- A write strobe in the same cycle as the `module_done` rising edge is still captured.

## Test plan
- Reset, `enable`=1: one `start_out` pulse. Write x=0..639 with depth = x mod 256, then raise `module_done`. Expect 640 beats: beat 0 has `m_tuser`=1 and `m_tdata`=24'h0000FF; beat 639 has `m_tlast`=1; a second `start_out` pulses 1 cycle after the swap.
- Depth 200 and 250 written → both beats 24'h000000. Depth 5 → 24'h0514FA.
- Random `m_tready` (50%) over 3 lines: no lost or duplicated beats, data stable during stalls, exactly 3×640 beats, `m_tuser` only on the first beat.
- Drive 480 lines, then a 481st: `m_tuser`=1 again on the first beat of line 481 (frame wrap).
- Only 639 writes before `module_done` → `err`=1, line still streamed. Separately, a write to addr 700 → `err`=1 and no RAM write.
- Engine finishes line 2 while line 1 is stalled (`m_tready`=0): no `start_out` until line 1's last beat is accepted. Then drop `enable`: line 2 streams and `start_out` stays low.
